clock_divider_bank: RTL and testbench

- Multi-channel programmable clock generator driven from the single system clock.
- Successor to the free-running single clock source: N_CH independent divided outputs, each with a runtime-programmable ratio, plus a one-cycle wrap tick per channel.
- Ratio changes take effect only at a period boundary, so no output shows a runt or stretched phase.
- A global sync clear phase-aligns all channels.

---
 rtl/clock_divider_bank.sv | 89 ++++++++
 tb/tb_clock_divider_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel programmable clock divider with period-aligned ratio updates
module clock_divider_bank #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync_clr,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             pend_flag;
    logic             out_q;
    logic             tick_q;

    logic [DIV_W:0]   half;
    logic [DIV_W-1:0] last;
    logic             off;
    logic             at_last;
    logic             apply;
    logic             wr_hit;

    // Period decode: high-phase length, final count, and whether this edge is a safe ratio-swap point
    always_comb begin
      half    = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
      last    = div_act - DIV_W'(1);
      off     = (div_act == '0);
      at_last = !off && (cnt == last);
      apply   = sync_clr || off || at_last;
      // Out-of-range channel numbers never match any index, so such writes fall through untouched
      wr_hit  = wr_en && (wr_ch == CH_W'(g));
    end

    // Counter and registered outputs, plus ratio hand-over only on a period boundary or sync clear
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt       <= '0;
        div_act   <= DIV_W'(DEFAULT_DIV);
        div_pend  <= DIV_W'(DEFAULT_DIV);
        pend_flag <= 1'b0;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        if (sync_clr || off) begin
          cnt    <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          out_q  <= ({1'b0, cnt} < half);
          tick_q <= at_last;
          cnt    <= at_last ? '0 : cnt + DIV_W'(1);
        end

        // Outputs above still used the old ratio; a swapped-in ratio starts from count zero next cycle
        if (apply) begin
          if (wr_hit) begin
            div_act   <= wr_div;
            div_pend  <= wr_div;
            pend_flag <= 1'b0;
            cnt       <= '0;
          end else if (pend_flag) begin
            div_act   <= div_pend;
            pend_flag <= 1'b0;
            cnt       <= '0;
          end
        end else if (wr_hit) begin
          div_pend  <= wr_div;
          pend_flag <= 1'b1;
        end
      end
    end

    assign clk_out[g] = out_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_flag;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed self-checking bench for clock_divider_bank
module tb_clock_divider_bank;
  localparam int N_CH  = 5;
  localparam int DIV_W = 8;
  localparam int CH_W  = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic             sync_clr;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_bank #(
    .N_CH(N_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(2)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .sync_clr(sync_clr),
    .clk_out(clk_out),
    .tick(tick),
    .pending(pending)
  );

  always #5 CLK = ~CLK;

  // Waveform of a divide-by-d output, i cycles after the period start
  function automatic logic exp_hi(input int d, input int i);
    if (d == 0) return 1'b0;
    return (i % d) < ((d + 1) / 2);
  endfunction

  function automatic logic exp_tk(input int d, input int i);
    if (d == 0) return 1'b0;
    return (i % d) == (d - 1);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = DIV_W'(d);
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_div   = '0;
    sync_clr = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [N_CH-1:0] ec, et;
    RST_N = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync_clr = 1'b0;
    step();
    n_checks++; if (clk_out !== '0) begin n_fail++; $display("FAIL rst_clk_out got=%b exp=%b", clk_out, 5'b0); end
    n_checks++; if (tick !== '0) begin n_fail++; $display("FAIL rst_tick got=%b exp=%b", tick, 5'b0); end
    n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL rst_pending got=%b exp=%b", pending, 5'b0); end
    step();
    RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      ec = (k % 2 == 1) ? '1 : '0;
      et = (k % 2 == 1) ? '0 : '1;
      n_checks++; if (clk_out !== ec) begin n_fail++; $display("FAIL rst_toggle_clk edge=%0d got=%b exp=%b", k, clk_out, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL rst_toggle_tick edge=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  task automatic test_write_pending();
    logic [N_CH-1:0] ec, et;
    int d[N_CH];
    do_reset();
    wr(1, 5);
    step();
    wr_en = 1'b0;
    n_checks++; if (pending !== 5'b00010) begin n_fail++; $display("FAIL wp_pending_set got=%b exp=%b", pending, 5'b00010); end
    n_checks++; if (clk_out !== 5'b11111) begin n_fail++; $display("FAIL wp_clk_e1 got=%b exp=%b", clk_out, 5'b11111); end
    step();
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL wp_pending_clr got=%b exp=%b", pending, 5'b00000); end
    n_checks++; if (clk_out !== 5'b00000) begin n_fail++; $display("FAIL wp_clk_e2 got=%b exp=%b", clk_out, 5'b00000); end
    n_checks++; if (tick !== 5'b11111) begin n_fail++; $display("FAIL wp_tick_e2 got=%b exp=%b", tick, 5'b11111); end
    for (int c = 0; c < N_CH; c++) d[c] = (c == 1) ? 5 : 2;
    for (int i = 0; i < 10; i++) begin
      step();
      for (int c = 0; c < N_CH; c++) begin ec[c] = exp_hi(d[c], i); et[c] = exp_tk(d[c], i); end
      n_checks++; if (clk_out !== ec) begin n_fail++; $display("FAIL wp_clk i=%0d got=%b exp=%b", i, clk_out, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL wp_tick i=%0d got=%b exp=%b", i, tick, et); end
    end
  endtask

  task automatic test_last_write_wins();
    do_reset();
    step();
    wr(2, 5);
    step();
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL lw_bypass_pending got=%b exp=%b", pending, 5'b00000); end
    wr(2, 7);
    step();
    n_checks++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL lw_pending_first got=%b exp=%b", pending, 5'b00100); end
    wr(2, 4);
    step();
    wr_en = 1'b0;
    n_checks++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL lw_pending_second got=%b exp=%b", pending, 5'b00100); end
    step();
    step();
    n_checks++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL lw_pending_hold got=%b exp=%b", pending, 5'b00100); end
    step();
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL lw_pending_applied got=%b exp=%b", pending, 5'b00000); end
    n_checks++; if (tick[2] !== 1'b1 || clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL lw_wrap_edge got clk=%b tick=%b exp clk=0 tick=1", clk_out[2], tick[2]); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (clk_out[2] !== exp_hi(4, i)) begin n_fail++; $display("FAIL lw_clk i=%0d got=%b exp=%b", i, clk_out[2], exp_hi(4, i)); end
      n_checks++; if (tick[2] !== exp_tk(4, i)) begin n_fail++; $display("FAIL lw_tick i=%0d got=%b exp=%b", i, tick[2], exp_tk(4, i)); end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    step();
    wr(0, 3);
    step();
    wr_en = 1'b0;
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL bp_pending got=%b exp=%b", pending, 5'b00000); end
    n_checks++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b1) begin n_fail++; $display("FAIL bp_wrap_edge got clk=%b tick=%b exp clk=0 tick=1", clk_out[0], tick[0]); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++; if (clk_out[0] !== exp_hi(3, i)) begin n_fail++; $display("FAIL bp_clk i=%0d got=%b exp=%b", i, clk_out[0], exp_hi(3, i)); end
      n_checks++; if (tick[0] !== exp_tk(3, i)) begin n_fail++; $display("FAIL bp_tick i=%0d got=%b exp=%b", i, tick[0], exp_tk(3, i)); end
      n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL bp_pending_run i=%0d got=%b exp=%b", i, pending, 5'b00000); end
    end
  endtask

  task automatic test_channel_off();
    logic [N_CH-1:0] ec, et;
    int d[N_CH];
    do_reset();
    step();
    wr(3, 0);
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 6) wr(3, 1);
      else if (i == 11) wr(5, 9);
      else if (i == 12) wr(7, 0);
      else wr_en = 1'b0;
      step();
      for (int c = 0; c < N_CH; c++) d[c] = (c == 3) ? ((i < 7) ? 0 : 1) : 2;
      for (int c = 0; c < N_CH; c++) begin ec[c] = exp_hi(d[c], i); et[c] = exp_tk(d[c], i); end
      n_checks++; if (clk_out !== ec) begin n_fail++; $display("FAIL off_clk i=%0d got=%b exp=%b", i, clk_out, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL off_tick i=%0d got=%b exp=%b", i, tick, et); end
      n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL off_pending i=%0d got=%b exp=%b", i, pending, 5'b00000); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_sync_clr();
    logic [N_CH-1:0] ec, et;
    int d[N_CH];
    do_reset();
    wr(0, 6); step();
    wr(1, 3); step();
    wr_en = 1'b0; step();
    wr(2, 6); step();
    wr_en = 1'b0; step(); step();
    wr(2, 4); step();
    n_checks++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL sc_pending_before got=%b exp=%b", pending, 5'b00100); end
    wr_en = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    n_checks++; if (clk_out !== 5'b00000) begin n_fail++; $display("FAIL sc_clk_clear got=%b exp=%b", clk_out, 5'b00000); end
    n_checks++; if (tick !== 5'b00000) begin n_fail++; $display("FAIL sc_tick_clear got=%b exp=%b", tick, 5'b00000); end
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL sc_pending_applied got=%b exp=%b", pending, 5'b00000); end
    d[0] = 6; d[1] = 3; d[2] = 4; d[3] = 2; d[4] = 2;
    for (int i = 0; i < 12; i++) begin
      step();
      for (int c = 0; c < N_CH; c++) begin ec[c] = exp_hi(d[c], i); et[c] = exp_tk(d[c], i); end
      n_checks++; if (clk_out !== ec) begin n_fail++; $display("FAIL sc_clk i=%0d got=%b exp=%b", i, clk_out, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL sc_tick i=%0d got=%b exp=%b", i, tick, et); end
    end
    sync_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (clk_out !== 5'b00000 || tick !== 5'b00000) begin n_fail++; $display("FAIL sc_held i=%0d got clk=%b tick=%b exp 00000", i, clk_out, tick); end
    end
    sync_clr = 1'b0;
    step();
    n_checks++; if (clk_out !== 5'b11111) begin n_fail++; $display("FAIL sc_release_clk got=%b exp=%b", clk_out, 5'b11111); end
    n_checks++; if (tick !== 5'b00000) begin n_fail++; $display("FAIL sc_release_tick got=%b exp=%b", tick, 5'b00000); end
  endtask

  task automatic test_reset_mid();
    logic [N_CH-1:0] ec, et;
    do_reset();
    wr(1, 5);
    step();
    wr_en = 1'b0;
    n_checks++; if (pending !== 5'b00010) begin n_fail++; $display("FAIL rm_pending_before got=%b exp=%b", pending, 5'b00010); end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++; if (clk_out !== 5'b00000) begin n_fail++; $display("FAIL rm_clk_async got=%b exp=%b", clk_out, 5'b00000); end
    n_checks++; if (tick !== 5'b00000) begin n_fail++; $display("FAIL rm_tick_async got=%b exp=%b", tick, 5'b00000); end
    n_checks++; if (pending !== 5'b00000) begin n_fail++; $display("FAIL rm_pending_async got=%b exp=%b", pending, 5'b00000); end
    step();
    RST_N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      ec = (k % 2 == 1) ? '1 : '0;
      et = (k % 2 == 1) ? '0 : '1;
      n_checks++; if (clk_out !== ec) begin n_fail++; $display("FAIL rm_clk edge=%0d got=%b exp=%b", k, clk_out, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL rm_tick edge=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  initial begin
    RST_N = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync_clr = 1'b0;
    test_reset();
    test_write_pending();
    test_last_write_wins();
    test_bypass();
    test_channel_off();
    test_sync_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
